// File: rtl/formal_vector_checker.sv
// formal_vector_checker: compares a WIDTH-bit fabric output vector against a
// reference vector once per cycle after a skip window. It counts per-bit
// mismatch rising edges, captures the first failure and reports pass/fail.
// Optional build macro FORMAL_VECTOR_CHECKER_STOP_ON_ERR_EN ends the run on
// the first failing compare cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start after reset
// ST_SKIP | initialisation window; inputs ignored
// ST_RUN  | compare cycles, run index k = RUN_CYCLES-1 - cnt_q
// ST_DONE | results held until start or reset
module formal_vector_checker #(
   parameter int WIDTH       = 8,
   parameter int SKIP_CYCLES = 1,
   parameter int RUN_CYCLES  = 10,
   parameter int ERR_W       = 16,
   parameter int CYC_W       = 16,
   localparam int BIT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] gfpga,
   input  logic [WIDTH-1:0] bench,
   input  logic [WIDTH-1:0] cmp_mask,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] nb_error,
   output logic [WIDTH-1:0] mismatch_flag,
   output logic             first_err_valid,
   output logic [BIT_W-1:0] first_err_bit,
   output logic [CYC_W-1:0] first_err_cycle
);

   typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_RUN, ST_DONE} state_t;

   // sum is wide enough for the counter plus a popcount of up to 64 bits
   localparam int SUM_W = ((ERR_W > 7) ? ERR_W : 7) + 1;
   localparam logic [SUM_W-1:0] ERR_MAX   = {{(SUM_W-ERR_W){1'b0}}, {ERR_W{1'b1}}};
   localparam logic [CYC_W-1:0] SKIP_LAST = CYC_W'(SKIP_CYCLES - 1);
   localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(RUN_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] flag_q, flag_d;
   logic [ERR_W-1:0] nb_q, nb_d;
   logic             fv_q, fv_d;
   logic [BIT_W-1:0] fbit_q, fbit_d;
   logic [CYC_W-1:0] fcyc_q, fcyc_d;

   logic [WIDTH-1:0] diff, rise;
   logic [SUM_W-1:0] pop, sum;
   logic [BIT_W-1:0] low_idx;
   logic             first_hit;

   // compare datapath: masked difference, new mismatches, their count and lowest index
   always_comb begin
      diff    = (gfpga ^ bench) & cmp_mask;
      rise    = diff & ~flag_q;
      pop     = '0;
      low_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + SUM_W'(rise[i]);
      end
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (rise[i]) low_idx = BIT_W'(i);
      end
      sum       = SUM_W'(nb_q) + pop;
      first_hit = (rise != '0) && !fv_q;
   end

   // sequencing FSM and result updates
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      nb_d    = nb_q;
      fv_d    = fv_q;
      fbit_d  = fbit_q;
      fcyc_d  = fcyc_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               flag_d = '0;
               nb_d   = '0;
               fv_d   = 1'b0;
               fbit_d = '0;
               fcyc_d = '0;
               if (SKIP_CYCLES == 0) begin
                  state_d = ST_RUN;
                  cnt_d   = RUN_LAST;
               end else begin
                  state_d = ST_SKIP;
                  cnt_d   = SKIP_LAST;
               end
            end
         end
         ST_SKIP: begin
            if (cnt_q == '0) begin
               state_d = ST_RUN;
               cnt_d   = RUN_LAST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RUN: begin
            flag_d = diff;
            nb_d   = (sum > ERR_MAX) ? ERR_W'(ERR_MAX) : ERR_W'(sum);
            if (first_hit) begin
               fv_d   = 1'b1;
               fbit_d = low_idx;
               fcyc_d = RUN_LAST - cnt_q;
            end
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
`ifdef FORMAL_VECTOR_CHECKER_STOP_ON_ERR_EN
            if (first_hit) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end
`else
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         flag_q  <= '0;
         nb_q    <= '0;
         fv_q    <= 1'b0;
         fbit_q  <= '0;
         fcyc_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         nb_q    <= nb_d;
         fv_q    <= fv_d;
         fbit_q  <= fbit_d;
         fcyc_q  <= fcyc_d;
      end
   end

   assign busy            = (state_q == ST_SKIP) || (state_q == ST_RUN);
   assign done            = (state_q == ST_DONE);
   assign pass            = done && (nb_q == '0);
   assign nb_error        = nb_q;
   assign mismatch_flag   = flag_q;
   assign first_err_valid = fv_q;
   assign first_err_bit   = fbit_q;
   assign first_err_cycle = fcyc_q;

endmodule

// File: tb/tb_formal_vector_checker.sv
// Bench for formal_vector_checker: two instances (ERR_W=16 and ERR_W=2) share
// stimulus; a per-run reference model computes flags, event counts and the
// first failure from the behavioural rules and is compared every cycle.
module tb_formal_vector_checker;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [7:0]  gfpga, bench, cmp_mask;

   logic        busy, done, pass, fev;
   logic [15:0] nb_error, fec;
   logic [7:0]  mismatch_flag;
   logic [2:0]  feb;

   logic        s_busy, s_done, s_pass, s_fev;
   logic [1:0]  s_nb;
   logic [15:0] s_fec;
   logic [7:0]  s_flag;
   logic [2:0]  s_feb;

   int n_cmp = 0;
   int n_err = 0;

   // stimulus per run: index 0 is the skip cycle, index k+1 is RUN cycle k
   logic [7:0] sg [0:10];
   logic [7:0] sb [0:10];
   logic [7:0] sm [0:10];

   // reference model state
   logic [7:0] mflag;
   int         m16, m2, mfb, mfc;
   bit         mfv, stopped;

   always #5 clk = ~clk;

   formal_vector_checker #(.WIDTH(8), .SKIP_CYCLES(1), .RUN_CYCLES(10), .ERR_W(16), .CYC_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .gfpga(gfpga), .bench(bench), .cmp_mask(cmp_mask),
      .busy(busy), .done(done), .pass(pass), .nb_error(nb_error), .mismatch_flag(mismatch_flag),
      .first_err_valid(fev), .first_err_bit(feb), .first_err_cycle(fec));

   formal_vector_checker #(.WIDTH(8), .SKIP_CYCLES(1), .RUN_CYCLES(10), .ERR_W(2), .CYC_W(16)) dut_sat (
      .clk(clk), .reset(reset), .start(start), .gfpga(gfpga), .bench(bench), .cmp_mask(cmp_mask),
      .busy(s_busy), .done(s_done), .pass(s_pass), .nb_error(s_nb), .mismatch_flag(s_flag),
      .first_err_valid(s_fev), .first_err_bit(s_feb), .first_err_cycle(s_fec));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
      chk({tag, "_nb"}, {48'd0, nb_error}, 64'd0);
      chk({tag, "_flag"}, {56'd0, mismatch_flag}, 64'd0);
      chk({tag, "_fev"}, {63'd0, fev}, 64'd0);
      chk({tag, "_feb"}, {61'd0, feb}, 64'd0);
      chk({tag, "_fec"}, {48'd0, fec}, 64'd0);
      chk({tag, "_s_nb"}, {62'd0, s_nb}, 64'd0);
      chk({tag, "_s_busy"}, {63'd0, s_busy}, 64'd0);
   endtask

   task automatic fill_clean();
      for (int i = 0; i <= 10; i++) begin
         sg[i] = 8'($urandom);
         sb[i] = sg[i];
         sm[i] = 8'hFF;
      end
   endtask

   task automatic model_step(input int k);
      logic [7:0] d, r;
      int p;
      d = (sg[k+1] ^ sb[k+1]) & sm[k+1];
      r = d & ~mflag;
      p = $countones(r);
      m16 = (m16 + p > 65535) ? 65535 : m16 + p;
      m2  = (m2 + p > 3) ? 3 : m2 + p;
      if (r != 8'h00 && !mfv) begin
         mfv = 1'b1;
         mfc = k;
         for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
               mfb = i;
               break;
            end
         end
`ifdef FORMAL_VECTOR_CHECKER_STOP_ON_ERR_EN
         stopped = 1'b1;
`endif
      end
      mflag = d;
   endtask

   // one check run; abort_at >= 0 asserts reset during that RUN cycle,
   // poke_start holds start high while the checker is busy
   task automatic do_run(input string tag, input int abort_at, input bit poke_start);
      bit at_done;
      mflag = 8'h00; m16 = 0; m2 = 0; mfb = 0; mfc = 0; mfv = 1'b0; stopped = 1'b0;
      at_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      gfpga = 8'($urandom);
      bench = gfpga;
      cmp_mask = 8'hFF;
      @(negedge clk);
      start = poke_start;
      gfpga = sg[0]; bench = sb[0]; cmp_mask = sm[0];
      chk({tag, "_skip_busy"}, {63'd0, busy}, 64'd1);
      chk({tag, "_skip_nb"}, {48'd0, nb_error}, 64'd0);
      chk({tag, "_skip_flag"}, {56'd0, mismatch_flag}, 64'd0);
      chk({tag, "_skip_fev"}, {63'd0, fev}, 64'd0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk({tag, "_run_busy"}, {63'd0, busy}, {63'd0, !stopped});
         chk({tag, "_run_done"}, {63'd0, done}, {63'd0, stopped});
         chk({tag, "_run_flag"}, {56'd0, mismatch_flag}, {56'd0, mflag});
         chk({tag, "_run_nb"}, {48'd0, nb_error}, 64'(m16));
         chk({tag, "_run_s_nb"}, {62'd0, s_nb}, 64'(m2));
         if (stopped) begin
            at_done = 1'b1;
            break;
         end
         if (k == abort_at) begin
            reset = 1'b1;
            start = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            chk_zero({tag, "_abort"});
            repeat (3) begin
               @(negedge clk);
               chk({tag, "_abort_nodone"}, {63'd0, done}, 64'd0);
               chk({tag, "_abort_idle"}, {63'd0, busy}, 64'd0);
            end
            return;
         end
         gfpga = sg[k+1]; bench = sb[k+1]; cmp_mask = sm[k+1];
         start = poke_start;
         model_step(k);
      end
      if (!at_done) @(negedge clk);
      start = 1'b0;
      chk({tag, "_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_pass"}, {63'd0, pass}, {63'd0, (m16 == 0)});
      chk({tag, "_nb"}, {48'd0, nb_error}, 64'(m16));
      chk({tag, "_flag"}, {56'd0, mismatch_flag}, {56'd0, mflag});
      chk({tag, "_fev"}, {63'd0, fev}, {63'd0, mfv});
      chk({tag, "_feb"}, {61'd0, feb}, 64'(mfb));
      chk({tag, "_fec"}, {48'd0, fec}, 64'(mfc));
      chk({tag, "_s_nb"}, {62'd0, s_nb}, 64'(m2));
      chk({tag, "_s_pass"}, {63'd0, s_pass}, {63'd0, (m2 == 0)});
      @(negedge clk);
      chk({tag, "_hold_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_hold_nb"}, {48'd0, nb_error}, 64'(m16));
      chk({tag, "_hold_flag"}, {56'd0, mismatch_flag}, {56'd0, mflag});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; gfpga = 8'h00; bench = 8'h00; cmp_mask = 8'h00;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;

      fill_clean();
      do_run("clean", -1, 1'b0);

      fill_clean();
      sb[0] = sg[0] ^ 8'h01;
      do_run("skip", -1, 1'b0);
      chk("skip_const_nb", {48'd0, nb_error}, 64'd0);

      fill_clean();
      for (int k = 2; k <= 4; k++) sb[k+1] = sg[k+1] ^ 8'h08;
      sb[7] = sg[7] ^ 8'h08;
      sb[9] = sg[9] ^ 8'h21;
      do_run("count", -1, 1'b0);
`ifndef FORMAL_VECTOR_CHECKER_STOP_ON_ERR_EN
      chk("count_const_nb", {48'd0, nb_error}, 64'd4);
      chk("count_const_s_nb", {62'd0, s_nb}, 64'd3);
`endif
      chk("count_const_feb", {61'd0, feb}, 64'd3);
      chk("count_const_fec", {48'd0, fec}, 64'd2);

      fill_clean();
      for (int i = 0; i <= 10; i++) begin sb[i] = sg[i] ^ 8'hF0; sm[i] = 8'h0F; end
      do_run("mask_lo", -1, 1'b0);
      chk("mask_lo_const_nb", {48'd0, nb_error}, 64'd0);
      for (int i = 0; i <= 10; i++) sm[i] = 8'hFF;
      do_run("mask_all", -1, 1'b0);
      chk("mask_all_const_nb", {48'd0, nb_error}, 64'd4);
      chk("mask_all_const_feb", {61'd0, feb}, 64'd4);

      fill_clean();
      for (int k = 0; k < 10; k += 2) sb[k+1] = sg[k+1] ^ 8'hFF;
      do_run("toggle", -1, 1'b0);
      chk("toggle_const_s_nb", {62'd0, s_nb}, 64'd3);

      fill_clean();
      sb[5] = sg[5] ^ 8'h40;
      do_run("single_k4", -1, 1'b0);
      chk("single_k4_const_nb", {48'd0, nb_error}, 64'd1);

      fill_clean();
      sb[2] = sg[2] ^ 8'h12;
      sb[4] = sg[4] ^ 8'h80;
      do_run("abort", 5, 1'b0);

      fill_clean();
      for (int k = 2; k <= 4; k++) sb[k+1] = sg[k+1] ^ 8'h08;
      sb[9] = sg[9] ^ 8'h21;
      do_run("poke_start", -1, 1'b1);
      do_run("rerun", -1, 1'b0);

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i <= 10; i++) begin
            sg[i] = 8'($urandom);
            sb[i] = sg[i] ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            sm[i] = (t < 10) ? 8'hFF : 8'($urandom);
         end
         do_run("random", -1, t[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
